mem_req_arbiter: RTL and testbench

Shares the single memory-mapped port of the mmu between NUM_REQ requesters (index 0 = Ibex instruction, 1 = Ibex data, 2 = Vicuna vproc).
- Grants one requester at a time and holds its request stable on the mmu side while the transaction is in flight.
- Routes the mmu response (rvalid/err/rdata) back to the owning requester.
- A timeout counter closes transactions the mmu never acknowledges, e.g. GPIO/timer writes.

---
 rtl/mem_req_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the single mmu memory port between NUM_REQ requesters.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_req_arbiter #(
    parameter int MEM_W          = 32,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*32-1:0]      addr_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*MEM_W/8-1:0] be_i,
    input  logic [NUM_REQ*MEM_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [NUM_REQ-1:0]         err_o,
    output logic [MEM_W-1:0]           rdata_o,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [MEM_W/8-1:0]         mem_be_o,
    output logic [MEM_W-1:0]           mem_wdata_o,
    input  logic                       mem_rvalid_i,
    input  logic                       mem_err_i,
    input  logic [MEM_W-1:0]           mem_rdata_i
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = MEM_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [PW-1:0]      r_owner;
    logic [TW-1:0]      r_tcnt;
    logic               r_iss2;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [BW-1:0]      r_be;
    logic [MEM_W-1:0]   r_wdata;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [NUM_REQ-1:0] r_err;
    logic [MEM_W-1:0]   r_rdata;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_take;
    logic               w_ok;
    logic               w_fail;
    logic               w_resp_en;
    logic [NUM_REQ-1:0] w_own_1h;
    logic [31:0]        w_sel_addr;
    logic               w_sel_we;
    logic [BW-1:0]      w_sel_be;
    logic [MEM_W-1:0]   w_sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [PW-1:0] r_rr;

    always_ff @(posedge clk) begin
        if (!rst)
            r_rr <= '0;
        else if (w_take)
            r_rr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
    end
`endif

    // Scan starts at the round-robin pointer (or index 0 for fixed priority)
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_idx = PW'(i);
`else
            w_idx = PW'((int'(r_rr) + i) % NUM_REQ);
`endif
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_sel_addr  = addr_i[32*i +: 32];
                w_sel_we    = we_i[i];
                w_sel_be    = be_i[BW*i +: BW];
                w_sel_wdata = wdata_i[MEM_W*i +: MEM_W];
            end
        end
    end

    assign w_resp_en = (r_state == S_WAIT) ||
                       ((r_state == S_ISSUE) && r_iss2);
    assign w_own_1h  = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_state_n = r_state;
        w_gnt     = '0;
        w_take    = 1'b0;
        w_ok      = 1'b0;
        w_fail    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && rst) begin
                    w_gnt[w_win] = 1'b1;
                    w_take       = 1'b1;
                    w_state_n    = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                // error beats rvalid, any response beats the timeout
                if (w_resp_en && mem_err_i)
                    w_fail = 1'b1;
                else if (w_resp_en && mem_rvalid_i)
                    w_ok = 1'b1;
                else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1))
                    w_fail = 1'b1;
                if (w_ok || w_fail)
                    w_state_n = S_IDLE;
                else if ((r_state == S_ISSUE) && r_iss2)
                    w_state_n = S_WAIT;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_tcnt   <= '0;
            r_iss2   <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_iss2   <= (r_state == S_ISSUE);
            r_rvalid <= '0;
            r_err    <= '0;
            if (w_take) begin
                r_owner <= w_win;
                r_tcnt  <= '0;
                r_addr  <= w_sel_addr;
                r_we    <= w_sel_we;
                r_be    <= w_sel_be;
                r_wdata <= w_sel_wdata;
            end else if (r_state != S_IDLE) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_ok) begin
                r_rvalid <= w_own_1h;
                r_rdata  <= mem_rdata_i;
            end
            if (w_fail)
                r_err <= w_own_1h;
        end
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign mem_req_o   = (r_state == S_ISSUE);
    assign mem_addr_o  = r_addr;
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and random stimulus against a transaction-level model.
// Honours MEM_ARB_FIXED_PRIO_EN the same way as the design.
module tb_mem_req_arbiter;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int T  = 16;
    localparam int BW = W / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*32-1:0] addr_i;
    logic [N-1:0]    we_i;
    logic [N*BW-1:0] be_i;
    logic [N*W-1:0]  wdata_i;
    logic [N-1:0]    gnt_o, rvalid_o, err_o;
    logic [W-1:0]    rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [31:0]     mem_addr_o;
    logic [BW-1:0]   mem_be_o;
    logic [W-1:0]    mem_wdata_o;
    logic            mem_rvalid_i, mem_err_i;
    logic [W-1:0]    mem_rdata_i;

    always #5 clk = ~clk;

    mem_req_arbiter #(.MEM_W(W), .NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .err_o(err_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
    );

    int npass = 0;
    int ntot  = 0;

    // Model: busy transaction aged in cycles since its grant
    bit           busy;
    int           age, rr, own, gk;
    logic [31:0]  m_addr;
    logic         m_we;
    logic [BW-1:0] m_be;
    logic [W-1:0] m_wd, m_rdata;
    logic [N-1:0] m_rv, m_er;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int j;
`ifdef MEM_ARB_FIXED_PRIO_EN
            j = i;
`else
            j = (rr + i) % N;
`endif
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [N-1:0] eg;
        int k;
        eg = '0;
        k = pick(req_i);
        if (rst && !busy && k >= 0) eg[k] = 1'b1;
        chk("gnt_o", gnt_o, eg);
        chk("mem_req_o", mem_req_o, busy && age <= 2);
        chk("mem_addr_o", mem_addr_o, m_addr);
        chk("mem_we_o", mem_we_o, m_we);
        chk("mem_be_o", mem_be_o, m_be);
        chk("mem_wdata_o", mem_wdata_o, m_wd);
        chk("rvalid_o", rvalid_o, m_rv);
        chk("err_o", err_o, m_er);
        chk("rdata_o", rdata_o, m_rdata);
    endtask

    task automatic model_update();
        gk = -1;
        if (!rst) begin
            busy = 0; rr = 0; own = 0; age = 0;
            m_addr = '0; m_we = 1'b0; m_be = '0; m_wd = '0;
            m_rdata = '0; m_rv = '0; m_er = '0;
        end else begin
            m_rv = '0;
            m_er = '0;
            if (!busy) begin
                gk = pick(req_i);
                if (gk >= 0) begin
                    busy = 1; age = 1; own = gk; rr = (gk + 1) % N;
                    m_addr = addr_i[32*gk +: 32];
                    m_we   = we_i[gk];
                    m_be   = be_i[BW*gk +: BW];
                    m_wd   = wdata_i[W*gk +: W];
                end
            end else if (age >= 2 && mem_err_i) begin
                m_er[own] = 1'b1; busy = 0;
            end else if (age >= 2 && mem_rvalid_i) begin
                m_rv[own] = 1'b1; m_rdata = mem_rdata_i; busy = 0;
            end else if (age == T) begin
                m_er[own] = 1'b1; busy = 0;
            end else begin
                age++;
            end
        end
    endtask

    task automatic cyc();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clr();
        req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic drain();
        clr();
        for (int c = 0; c < 40 && busy; c++) begin
            mem_rvalid_i = (age >= 2);
            cyc();
        end
        clr();
        chk("drain_busy", {63'b0, busy}, 64'd0);
    endtask

    bit           pend[N];
    logic [31:0]  ra[N];
    logic         rwe[N];
    logic [BW-1:0] rbe[N];
    logic [W-1:0] rwd[N];
    logic [N-1:0] got[6];
    logic [N-1:0] ev;
    logic [N-1:0] eg;
    int ng, first, seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        rst = 1'b0;
        busy = 0; age = 0; rr = 0; own = 0; gk = -1;
        m_addr = '0; m_we = 1'b0; m_be = '0; m_wd = '0;
        m_rdata = '0; m_rv = '0; m_er = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b1;
        #1 chk("rst_req", mem_req_o, 0);
        chk("rst_rv", rvalid_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        cyc();

        // single read from requester 2
        req_i = 3'b100; addr_i[95:64] = 32'h1004; be_i[11:8] = 4'hF;
        #1 chk("sr_gnt", gnt_o, 3'b100);
        cyc();
        req_i = '0; addr_i[95:64] = 32'hFFFF_0000;
        #1 chk("sr_req1", mem_req_o, 1);
        chk("sr_addr1", mem_addr_o, 32'h1004);
        cyc();
        #1 chk("sr_req2", mem_req_o, 1);
        chk("sr_addr2", mem_addr_o, 32'h1004);
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1 chk("sr_req3", mem_req_o, 0);
        chk("sr_addr3", mem_addr_o, 32'h1004);
        cyc();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1 chk("sr_rvalid", rvalid_o, 3'b100);
        chk("sr_rdata", rdata_o, 32'hDEADBEEF);
        cyc();
        #1 chk("sr_pulse", rvalid_o, 0);
        cyc();

        // contention, every access answered on its second issue cycle
        clr();
        req_i = '1; be_i = '1;
        addr_i = {32'h300, 32'h200, 32'h100};
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            mem_rvalid_i = busy && age == 2;
            mem_rdata_i = c;
            #1 if (gnt_o != '0) begin
                got[ng] = gnt_o;
                ng++;
            end
            cyc();
        end
        chk("cont_count", ng, 6);
        for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            eg = 3'b001;
`else
            eg = 3'b001 << (i % 3);
`endif
            chk($sformatf("cont_g%0d", i), got[i], eg);
        end
        drain();

        // silent timer write: closed by the timeout
        req_i = 3'b001; we_i = 3'b001; addr_i[31:0] = 32'h0115;
        be_i[3:0] = 4'hF; wdata_i[31:0] = 32'h5A5A;
        cyc();
        req_i = '0;
        first = -1; seen = -1; ev = '0;
        for (int c = 1; c <= 40; c++) begin
            #1 if (mem_req_o && first < 0) first = c;
            if (err_o != '0) begin
                seen = c;
                ev = err_o;
                break;
            end
            cyc();
        end
        chk("to_delay", seen - first, 16);
        chk("to_err", ev, 3'b001);
        chk("to_we", mem_we_o, 1);
        cyc();
        #1 chk("to_pulse", err_o, 0);
        chk("to_idle_req", mem_req_o, 0);
        cyc();

        // error together with rvalid: error wins
        clr();
        req_i = 3'b010; addr_i[63:32] = 32'h0050;
        cyc();
        req_i = '0;
        cyc();
        mem_err_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
        cyc();
        clr();
        #1 chk("ep_err", err_o, 3'b010);
        chk("ep_rv", rvalid_o, 0);
        cyc();

        // reset while waiting drops the access
        req_i = 3'b001; addr_i[31:0] = 32'hABC0;
        cyc();
        req_i = '0;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1 chk("rm_req", mem_req_o, 0);
        chk("rm_addr", mem_addr_o, 0);
        chk("rm_err", err_o, 0);
        chk("rm_rv", rvalid_o, 0);
        chk("rm_rdata", rdata_o, 0);
        chk("rm_gnt", gnt_o, 0);
        for (int c = 0; c < 5; c++) begin
            mem_rvalid_i = 1'b1; mem_err_i = c[0];
            cyc();
            #1 chk("rm_quiet", rvalid_o | err_o, 0);
        end
        clr();
        cyc();

        // random traffic
        for (int k = 0; k < N; k++) begin
            pend[k] = 0; ra[k] = '0; rwe[k] = 1'b0; rbe[k] = '0; rwd[k] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1;
                    ra[k] = $urandom; rwe[k] = 1'($urandom);
                    rbe[k] = BW'($urandom); rwd[k] = $urandom;
                end else if (pend[k] && $urandom_range(0, 49) == 0) begin
                    pend[k] = 0;
                end
                req_i[k] = pend[k];
                addr_i[32*k +: 32] = ra[k];
                we_i[k] = rwe[k];
                be_i[BW*k +: BW] = rbe[k];
                wdata_i[W*k +: W] = rwd[k];
            end
            mem_rvalid_i = ($urandom_range(0, 4) == 0);
            mem_err_i = ($urandom_range(0, 15) == 0);
            mem_rdata_i = $urandom;
            cyc();
            if (gk >= 0) begin
                pend[gk] = 0;
                ra[gk] = $urandom;
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
